fetch_decode: RTL

Instruction fetch and decode stage of the TD4 CPU, sitting directly upstream of the ALU. It reads the 8-bit instruction at the current program counter from the program ROM and splits it into a 4-bit opcode and a 4-bit immediate. It decodes the opcode into the `OPECODE` enumeration and presents the pair to the ALU for exactly one cycle per instruction. It also paces execution: free-running at a divided rate, single-step on a button pulse, or halted.

---
 rtl/fetch_decode_if.sv | 46 ++++
 rtl/fetch_decode.sv | 119 +++++++++++
 2 files changed

// File: rtl/fetch_decode_if.sv
// Opcode enumeration shared by the fetch/decode stage and its ALU, plus the stage's bus bundle.
// master = the fetch_decode stage itself; slave = the surrounding CPU/ROM/ALU.
package fetch_decode_pkg;
    typedef enum logic [3:0] {
        ADD_A_IMM = 4'h0,
        MOV_A_B   = 4'h1,
        IN_A      = 4'h2,
        MOV_A_IMM = 4'h3,
        MOV_B_A   = 4'h4,
        ADD_B_IMM = 4'h5,
        IN_B      = 4'h6,
        MOV_B_IMM = 4'h7,
        INVALID   = 4'h8,
        OUT_B     = 4'h9,
        OUT_IMM   = 4'hB,
        JNC_IMM   = 4'hE,
        JMP_IMM   = 4'hF
    } OPECODE;
endpackage

interface fetch_decode_if;
    import fetch_decode_pkg::*;

    logic        run;
    logic        step;
    logic        halt;
    logic [3:0]  pc;
    logic [3:0]  rom_addr;
    logic        rom_en;
    logic [7:0]  rom_data;
    OPECODE      opecode;
    logic [3:0]  imm;
    logic        issue;
    logic        busy;
    logic [15:0] retired;

    modport master (
        input  run, step, halt, pc, rom_data,
        output rom_addr, rom_en, opecode, imm, issue, busy, retired
    );

    modport slave (
        output run, step, halt, pc, rom_data,
        input  rom_addr, rom_en, opecode, imm, issue, busy, retired
    );
endinterface

// File: rtl/fetch_decode.sv
// TD4 fetch/decode: one instruction per 5-state pass (IDLE, FETCH, LATCH, ISSUE, COMMIT).
// Issue follows the accepted request by 3 cycles; halt holds requests in IDLE without losing them.
module fetch_decode
    import fetch_decode_pkg::*;
#(
    parameter int unsigned TICK_DIV = 8
) (
    input  logic           clk,
    input  logic           rst,
    fetch_decode_if.master bus
);

    localparam int unsigned   CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LATCH  = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic          step_q;
    logic          run_q;
    logic          mode_q;
    logic          mode_eff;
    logic          run_chg;
    logic          req;
    logic          pending;
    logic          fire;
    logic [7:0]    ir;
    logic [3:0]    rom_addr_q;
    logic          rom_en_q;
    logic [15:0]   retired_q;

    function automatic OPECODE decode(input logic [3:0] op);
        case (op)
            4'h0:    decode = ADD_A_IMM;
            4'h1:    decode = MOV_A_B;
            4'h2:    decode = IN_A;
            4'h3:    decode = MOV_A_IMM;
            4'h4:    decode = MOV_B_A;
            4'h5:    decode = ADD_B_IMM;
            4'h6:    decode = IN_B;
            4'h7:    decode = MOV_B_IMM;
            4'h9:    decode = OUT_B;
            4'hB:    decode = OUT_IMM;
            4'hE:    decode = JNC_IMM;
            4'hF:    decode = JMP_IMM;
            default: decode = INVALID;
        endcase
    endfunction

    assign tick     = (tick_cnt == TICK_LAST);
    assign run_chg  = (bus.run != run_q);
    // The mode is only re-read in IDLE; while busy, requests follow the mode the instruction started in.
    assign mode_eff = (state == S_IDLE) ? bus.run : mode_q;
    assign req      = mode_eff ? tick : (bus.step & ~step_q);
    assign fire     = (state == S_IDLE) && pending && !bus.halt && !run_chg;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (fire) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_LATCH;
            S_LATCH:  state_nxt = S_ISSUE;
            S_ISSUE:  state_nxt = S_COMMIT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            step_q     <= 1'b0;
            run_q      <= 1'b0;
            mode_q     <= 1'b0;
            pending    <= 1'b0;
            ir         <= 8'h00;
            rom_addr_q <= 4'h0;
            rom_en_q   <= 1'b0;
            retired_q  <= 16'h0000;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
            step_q   <= bus.step;
            run_q    <= bus.run;
            if (state == S_IDLE)
                mode_q <= bus.run;

            // A request arriving while one is already pending is dropped.
            if (run_chg || fire)
                pending <= 1'b0;
            else if (req)
                pending <= 1'b1;

            rom_en_q <= fire;
            if (fire)
                rom_addr_q <= bus.pc;
            if (state == S_LATCH)
                ir <= bus.rom_data;
            if (state == S_ISSUE)
                retired_q <= retired_q + 16'd1;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.rom_en   = rom_en_q;
    assign bus.issue    = (state == S_ISSUE);
    assign bus.busy     = (state != S_IDLE);
    assign bus.opecode  = (state == S_ISSUE) ? decode(ir[7:4]) : INVALID;
    assign bus.imm      = (state == S_ISSUE) ? ir[3:0] : 4'h0;
    assign bus.retired  = retired_q;

endmodule
